// File: rtl/render_pkg.sv
// -----------------------------------------------------------------------------
// render_pkg
// Shared types and constants for the image renderer.
//   fade_state_e  : fade controller states (DARK, FADING_IN, SHOWN, FADING_OUT)
//   LEVEL_MAX     : full-brightness fade level (16)
//   LEVEL_BITS    : width of the fade level (5 bits, holds 0..16)
//   scale_channel : (c * level) >> 4 on a 4-bit colour channel
// -----------------------------------------------------------------------------
package render_pkg;

   localparam int LEVEL_MAX  = 16;
   localparam int LEVEL_BITS = 5;

   localparam logic [LEVEL_BITS-1:0] LVL_MAX  = LEVEL_BITS'(LEVEL_MAX);
   localparam logic [LEVEL_BITS-1:0] LVL_ZERO = '0;

   typedef enum logic [1:0] {
      DARK       = 2'd0,
      FADING_IN  = 2'd1,
      SHOWN      = 2'd2,
      FADING_OUT = 2'd3
   } fade_state_e;

   // 9-bit product: 15 * 16 = 240, so level 16 returns c unchanged.
   function automatic logic [3:0] scale_channel(input logic [3:0]            c,
                                                input logic [LEVEL_BITS-1:0] lvl);
      logic [8:0] w_prod;
      w_prod = 9'(c) * 9'(lvl);
      return 4'(w_prod >> 4);
   endfunction

endpackage

// File: rtl/image_renderer_fade_ctrl.sv
// -----------------------------------------------------------------------------
// fade_ctrl
// Fade state machine plus frame counter. The level moves one step every
// FRAMES_PER_STEP frame ticks while fading.
//   i_clk, i_rst      : clock, async active-high reset
//   i_frame_tick      : one pulse per frame
//   i_fade_in_req     : single-cycle fade-in command
//   i_fade_out_req    : single-cycle fade-out command
//   o_fade_level      : current level 0..16
//   o_fade_busy       : high in FADING_IN / FADING_OUT
//   o_state           : current state (debug visibility)
// -----------------------------------------------------------------------------
module fade_ctrl
   import render_pkg::*;
#(
   parameter int FRAMES_PER_STEP = 2
)(
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_frame_tick,
   input  logic                  i_fade_in_req,
   input  logic                  i_fade_out_req,
   output logic [LEVEL_BITS-1:0] o_fade_level,
   output logic                  o_fade_busy,
   output fade_state_e           o_state
);

   localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

   fade_state_e           r_state, w_next;
   logic [LEVEL_BITS-1:0] r_level;
   logic [CNT_W-1:0]      r_cnt;
   logic                  w_in, w_out, w_req_take, w_cnt_last, w_step_due;

   // Both requests together cancel each other out.
   assign w_in  = i_fade_in_req  & ~i_fade_out_req;
   assign w_out = i_fade_out_req & ~i_fade_in_req;

   // A request that actually changes state takes priority over a coincident
   // tick; that tick is dropped and does not step the level.
   assign w_req_take = (((r_state == DARK)  || (r_state == FADING_OUT)) && w_in) ||
                       (((r_state == SHOWN) || (r_state == FADING_IN))  && w_out);
   assign w_cnt_last = (r_cnt == CNT_W'(FRAMES_PER_STEP - 1));
   assign w_step_due = i_frame_tick && w_cnt_last && !w_req_take;

   // State register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_state <= DARK;
      else       r_state <= w_next;
   end

   // Next-state logic. The terminal transition happens on the same edge
   // as the final level step; a level already at its end value (reversal
   // before any step) leaves immediately.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         DARK:       if (w_in) w_next = FADING_IN;
         FADING_IN:  if (w_out)                                       w_next = FADING_OUT;
                     else if ((r_level == LVL_MAX) ||
                              (w_step_due && (r_level == LVL_MAX - 1'b1))) w_next = SHOWN;
         SHOWN:      if (w_out) w_next = FADING_OUT;
         FADING_OUT: if (w_in)                                        w_next = FADING_IN;
                     else if ((r_level == LVL_ZERO) ||
                              (w_step_due && (r_level == LEVEL_BITS'(1)))) w_next = DARK;
         default:    w_next = DARK;
      endcase
   end

   // Outputs from state
   always_comb begin
      o_fade_busy = (r_state == FADING_IN) || (r_state == FADING_OUT);
   end

   // Frame counter and level
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_cnt   <= '0;
         r_level <= '0;
      end else begin
         if (r_state != w_next)
            r_cnt <= '0;
         else if (i_frame_tick)
            r_cnt <= w_cnt_last ? '0 : r_cnt + CNT_W'(1);

         if (w_step_due && (r_state == FADING_IN) && (r_level != LVL_MAX))
            r_level <= r_level + LEVEL_BITS'(1);
         else if (w_step_due && (r_state == FADING_OUT) && (r_level != LVL_ZERO))
            r_level <= r_level - LEVEL_BITS'(1);
      end
   end

   assign o_fade_level = r_level;
   assign o_state      = r_state;

endmodule

// File: rtl/image_renderer.sv
// -----------------------------------------------------------------------------
// image_renderer
// Scales an IMG_W x IMG_H palette-indexed image to the screen and applies a
// frame-based fade. Colour appears 3 vga_clk after its DrawX/DrawY.
//   vga_clk, reset         : pixel clock, async active-high reset
//   DrawX, DrawY           : current pixel coordinate
//   blank                  : high = active video
//   fade_in_req/out_req    : single-cycle fade commands
//   rom_address / rom_q    : image ROM (data one cycle after address)
//   pal_index / pal_*      : external combinational palette
//   red, green, blue       : final colour
//   fade_level, fade_busy  : fade status
//   dbg_fade_state         : fade FSM state (debug)
// -----------------------------------------------------------------------------
module image_renderer
   import render_pkg::*;
#(
   parameter int IMG_W           = 175,
   parameter int IMG_H           = 480,
   parameter int SCR_W           = 640,
   parameter int SCR_H           = 480,
   parameter int IDX_BITS        = 4,
   parameter int ADDR_BITS       = 17,
   parameter int FRAMES_PER_STEP = 2
)(
   input  logic                  vga_clk,
   input  logic                  reset,
   input  logic [9:0]            DrawX,
   input  logic [9:0]            DrawY,
   input  logic                  blank,
   input  logic                  fade_in_req,
   input  logic                  fade_out_req,
   output logic [ADDR_BITS-1:0]  rom_address,
   input  logic [IDX_BITS-1:0]   rom_q,
   output logic [IDX_BITS-1:0]   pal_index,
   input  logic [3:0]            pal_red,
   input  logic [3:0]            pal_green,
   input  logic [3:0]            pal_blue,
   output logic [3:0]            red,
   output logic [3:0]            green,
   output logic [3:0]            blue,
   output logic [LEVEL_BITS-1:0] fade_level,
   output logic                  fade_busy,
   output fade_state_e           dbg_fade_state
);

   localparam int XI_W = $clog2(IMG_W);
   localparam int XF_W = $clog2(SCR_W);
   localparam int YF_W = $clog2(SCR_H);

   logic [XF_W-1:0]      r_xf, w_xf_cur, w_xf_next;
   logic [XF_W:0]        w_xf_sum;
   logic [XI_W-1:0]      r_xi, w_xi_cur, w_xi_next;
   logic [YF_W-1:0]      r_yf, w_yf_cur, w_yf_step;
   logic [YF_W:0]        w_yf_sum;
   logic [ADDR_BITS-1:0] r_row_base, w_row_cur, w_row_step, r_rom_address;
   logic [9:0]           r_prev_y;
   logic                 w_x_zero, w_active, w_new_line;
   logic                 r_at_origin, w_frame_tick;
   logic [IDX_BITS-1:0]  r_pal_index;
   logic [1:0]           r_blank_d;
   logic [3:0]           r_red, r_green, r_blue;

   assign w_x_zero   = (DrawX == 10'd0);
   assign w_active   = (DrawX < 10'(SCR_W)) && (DrawY < 10'(SCR_H));
   assign w_new_line = w_x_zero && (DrawY != r_prev_y);

   // DDA: x carries integer column + remainder mod SCR_W; y keeps the row
   // base address (row * IMG_W) so no multiply by the row is needed.
   always_comb begin
      w_xf_cur = w_x_zero ? '0 : r_xf;
      w_xi_cur = w_x_zero ? '0 : r_xi;
      w_xf_sum = {1'b0, w_xf_cur} + (XF_W+1)'(IMG_W);
      if (w_xf_sum >= (XF_W+1)'(SCR_W)) begin
         w_xf_next = XF_W'(w_xf_sum - (XF_W+1)'(SCR_W));
         w_xi_next = w_xi_cur + XI_W'(1);
      end else begin
         w_xf_next = w_xf_sum[XF_W-1:0];
         w_xi_next = w_xi_cur;
      end

      w_yf_sum = {1'b0, r_yf} + (YF_W+1)'(IMG_H);
      if (w_yf_sum >= (YF_W+1)'(SCR_H)) begin
         w_yf_step  = YF_W'(w_yf_sum - (YF_W+1)'(SCR_H));
         w_row_step = r_row_base + ADDR_BITS'(IMG_W);
      end else begin
         w_yf_step  = w_yf_sum[YF_W-1:0];
         w_row_step = r_row_base;
      end

      // The new line's step is used in the same cycle so DrawX==0 of a new
      // line already addresses the new row.
      if (DrawY == 10'd0) begin
         w_yf_cur  = '0;
         w_row_cur = '0;
      end else if (w_new_line) begin
         w_yf_cur  = w_yf_step;
         w_row_cur = w_row_step;
      end else begin
         w_yf_cur  = r_yf;
         w_row_cur = r_row_base;
      end
   end

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         r_xf          <= '0;
         r_xi          <= '0;
         r_yf          <= '0;
         r_row_base    <= '0;
         r_prev_y      <= '0;
         r_rom_address <= '0;
      end else begin
         if (w_x_zero)
            r_prev_y <= DrawY;
         // Outside the visible area everything holds, including the address.
         if (w_active) begin
            r_xf          <= w_xf_next;
            r_xi          <= w_xi_next;
            r_yf          <= w_yf_cur;
            r_row_base    <= w_row_cur;
            r_rom_address <= ADDR_BITS'(w_xi_cur) + w_row_cur;
         end
      end
   end

   // Frame tick on the first cycle at the origin only.
   assign w_frame_tick = w_x_zero && (DrawY == 10'd0) && !r_at_origin;

   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) r_at_origin <= 1'b0;
      else       r_at_origin <= w_x_zero && (DrawY == 10'd0);
   end

   // Stage 2 (palette index) and stage 3 (scaled colour); blank follows the
   // data through two registers and gates the stage-3 colour register.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         r_pal_index <= '0;
         r_blank_d   <= '0;
         r_red       <= '0;
         r_green     <= '0;
         r_blue      <= '0;
      end else begin
         r_pal_index <= rom_q;
         r_blank_d   <= {r_blank_d[0], blank};
         if (r_blank_d[1]) begin
            r_red   <= scale_channel(pal_red,   fade_level);
            r_green <= scale_channel(pal_green, fade_level);
            r_blue  <= scale_channel(pal_blue,  fade_level);
         end else begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
         end
      end
   end

   fade_ctrl #(
      .FRAMES_PER_STEP (FRAMES_PER_STEP)
   ) u_fade_ctrl (
      .i_clk          (vga_clk),
      .i_rst          (reset),
      .i_frame_tick   (w_frame_tick),
      .i_fade_in_req  (fade_in_req),
      .i_fade_out_req (fade_out_req),
      .o_fade_level   (fade_level),
      .o_fade_busy    (fade_busy),
      .o_state        (dbg_fade_state)
   );

   assign rom_address = r_rom_address;
   assign pal_index   = r_pal_index;
   assign red         = r_red;
   assign green       = r_green;
   assign blue        = r_blue;

endmodule

// File: tb/tb_image_renderer.sv
// -----------------------------------------------------------------------------
// tb_image_renderer
// Directed bench: address table scan, fade sequences, blank alignment, reset.
// -----------------------------------------------------------------------------
module tb_image_renderer;
   import render_pkg::*;

   // ---------------- clock / reset / signals ----------------
   logic        vga_clk = 1'b0;
   logic        reset;
   logic [9:0]  DrawX, DrawY;
   logic        blank, fade_in_req, fade_out_req;
   logic [16:0] rom_address;
   logic [3:0]  rom_q, pal_index;
   logic [3:0]  pal_red, pal_green, pal_blue;
   logic [3:0]  red, green, blue;
   logic [4:0]  fade_level;
   logic        fade_busy;
   fade_state_e dbg_fade_state;

   always #5 vga_clk = ~vga_clk;

   image_renderer dut (
      .vga_clk        (vga_clk),
      .reset          (reset),
      .DrawX          (DrawX),
      .DrawY          (DrawY),
      .blank          (blank),
      .fade_in_req    (fade_in_req),
      .fade_out_req   (fade_out_req),
      .rom_address    (rom_address),
      .rom_q          (rom_q),
      .pal_index      (pal_index),
      .pal_red        (pal_red),
      .pal_green      (pal_green),
      .pal_blue       (pal_blue),
      .red            (red),
      .green          (green),
      .blue           (blue),
      .fade_level     (fade_level),
      .fade_busy      (fade_busy),
      .dbg_fade_state (dbg_fade_state)
   );

   // External palette model
   always_comb begin
      case (pal_index)
         4'd3:    {pal_red, pal_green, pal_blue} = {4'hA, 4'h5, 4'h1};
         4'd5:    {pal_red, pal_green, pal_blue} = {4'hF, 4'h8, 4'h3};
         default: {pal_red, pal_green, pal_blue} = {4'h2, 4'h2, 4'h2};
      endcase
   end

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic check_rgb(input string name, input logic [3:0] r, input logic [3:0] g,
                            input logic [3:0] b);
      check({name, "_red"},   32'(red),   32'(r));
      check({name, "_green"}, 32'(green), 32'(g));
      check({name, "_blue"},  32'(blue),  32'(b));
   endtask

   task automatic check_fade(input string name, input fade_state_e st, input int lvl,
                             input logic busy);
      check({name, "_state"}, 32'(dbg_fade_state), 32'(st));
      check({name, "_level"}, 32'(fade_level),     32'(lvl));
      check({name, "_busy"},  32'(fade_busy),      32'(busy));
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge vga_clk);
      #1;
   endtask

   // One frame tick: leave the origin, then return to it (optionally with requests).
   task automatic do_tick(input logic in_r, input logic out_r);
      DrawX = 10'd5; DrawY = 10'd5;
      step();
      DrawX = 10'd0; DrawY = 10'd0;
      fade_in_req = in_r; fade_out_req = out_r;
      step();
      fade_in_req = 1'b0; fade_out_req = 1'b0;
      DrawX = 10'd5; DrawY = 10'd5;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) do_tick(1'b0, 1'b0);
   endtask

   task automatic pulse_req(input logic in_r, input logic out_r);
      DrawX = 10'd5; DrawY = 10'd5;
      fade_in_req = in_r; fade_out_req = out_r;
      step();
      fade_in_req = 1'b0; fade_out_req = 1'b0;
   endtask

   task automatic settle3();
      DrawX = 10'd5; DrawY = 10'd5;
      repeat (3) step();
   endtask

   // ---------------- address vectors ----------------
   typedef struct {
      int    dy;
      int    dx_end;
      int    exp_addr;
      string name;
   } addr_vec_t;

   addr_vec_t vecs[8];

   initial begin
      vecs[0] = '{0,   639, 174,   "addr_y0_x639"};
      vecs[1] = '{0,   320, 87,    "addr_y0_x320"};
      vecs[2] = '{1,   0,   175,   "addr_y1_x0"};
      vecs[3] = '{0,   3,   0,     "addr_y0_x3"};
      vecs[4] = '{0,   4,   1,     "addr_y0_x4"};
      vecs[5] = '{2,   639, 524,   "addr_y2_x639"};
      vecs[6] = '{10,  100, 1777,  "addr_y10_x100"};
      vecs[7] = '{479, 639, 83999, "addr_y479_x639"};

      reset = 1'b1; DrawX = 10'd5; DrawY = 10'd5; blank = 1'b1;
      fade_in_req = 1'b0; fade_out_req = 1'b0; rom_q = 4'd3;

      // ---- reset state ----
      repeat (2) step();
      check("rst_addr", 32'(rom_address), 32'd0);
      check("rst_pal_index", 32'(pal_index), 32'd0);
      check_rgb("rst", 4'h0, 4'h0, 4'h0);
      check_fade("rst", DARK, 0, 1'b0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("post_rst_red", 32'(red), 32'd0);
      end

      // ---- address table: walk lines 0..dy at DrawX=0, then scan the line ----
      foreach (vecs[i]) begin
         for (int y = 0; y <= vecs[i].dy; y++) begin
            DrawX = 10'd0; DrawY = 10'(y);
            step();
         end
         for (int x = 1; x <= vecs[i].dx_end; x++) begin
            DrawX = 10'(x);
            step();
         end
         check(vecs[i].name, 32'(rom_address), 32'(vecs[i].exp_addr));
      end

      // ---- hold outside the visible area ----
      DrawX = 10'd700; DrawY = 10'd479; step();
      check("hold_x700", 32'(rom_address), 32'd83999);
      DrawX = 10'd100; DrawY = 10'd500; step();
      check("hold_y500", 32'(rom_address), 32'd83999);

      // ---- full fade-in; holding the origin produces only one tick ----
      pulse_req(1'b1, 1'b0);
      check_fade("fin_start", FADING_IN, 0, 1'b1);
      DrawX = 10'd0; DrawY = 10'd0;
      repeat (4) step();
      DrawX = 10'd5; DrawY = 10'd5;
      check_fade("fin_held_origin", FADING_IN, 0, 1'b1);
      ticks(1);
      check_fade("fin_tick2", FADING_IN, 1, 1'b1);
      ticks(29);
      check_fade("fin_tick31", FADING_IN, 15, 1'b1);
      ticks(1);
      check_fade("fin_tick32", SHOWN, 16, 1'b0);

      // ---- colour at level 16 ----
      rom_q = 4'd3;
      settle3();
      check("pal_index3", 32'(pal_index), 32'd3);
      check_rgb("lvl16", 4'hA, 4'h5, 4'h1);

      // ---- blank alignment: low for one cycle, black exactly two edges later ----
      blank = 1'b0; step();
      blank = 1'b1;
      check("blank_e0", 32'(red), 32'hA);
      step();
      check("blank_e1", 32'(red), 32'hA);
      step();
      check_rgb("blank_e2", 4'h0, 4'h0, 4'h0);
      step();
      check("blank_e3", 32'(red), 32'hA);

      // ---- fade-out to level 8, scaling, then to DARK ----
      pulse_req(1'b0, 1'b1);
      check_fade("fout_start", FADING_OUT, 16, 1'b1);
      ticks(16);
      rom_q = 4'd5;
      settle3();
      check_fade("fout_lvl8", FADING_OUT, 8, 1'b1);
      check_rgb("lvl8", 4'h7, 4'h4, 4'h1);
      ticks(16);
      check_fade("fout_dark", DARK, 0, 1'b0);
      settle3();
      check("lvl0_red", 32'(red), 32'd0);

      // ---- simultaneous requests in DARK are ignored ----
      pulse_req(1'b1, 1'b1);
      check_fade("both_dark", DARK, 0, 1'b0);

      // ---- reversal at level 5 ----
      pulse_req(1'b1, 1'b0);
      ticks(10);
      check_fade("rev_lvl5", FADING_IN, 5, 1'b1);
      pulse_req(1'b1, 1'b1);
      check_fade("both_fading", FADING_IN, 5, 1'b1);
      ticks(1);
      check_fade("rev_half", FADING_IN, 5, 1'b1);
      do_tick(1'b0, 1'b1);   // request wins over the tick that would reach 6
      check_fade("rev_take", FADING_OUT, 5, 1'b1);
      ticks(1);
      check_fade("rev_cnt_cleared", FADING_OUT, 5, 1'b1);
      ticks(1);
      check_fade("rev_lvl4", FADING_OUT, 4, 1'b1);
      ticks(7);
      check_fade("rev_lvl1", FADING_OUT, 1, 1'b1);
      ticks(1);
      check_fade("rev_dark", DARK, 0, 1'b0);

      // ---- reset in the middle of a fade ----
      pulse_req(1'b1, 1'b0);
      ticks(18);
      rom_q = 4'd3;
      settle3();
      check_fade("mid_lvl9", FADING_IN, 9, 1'b1);
      check_rgb("lvl9", 4'h5, 4'h2, 4'h0);
      #2 reset = 1'b1;
      #1;
      check_rgb("async_rst", 4'h0, 4'h0, 4'h0);
      check_fade("async_rst", DARK, 0, 1'b0);
      check("async_rst_addr", 32'(rom_address), 32'd0);
      check("async_rst_pal", 32'(pal_index), 32'd0);
      step();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("rerst_black", 32'(red), 32'd0);
      end
      pulse_req(1'b1, 1'b0);
      ticks(2);
      check_fade("restart", FADING_IN, 1, 1'b1);

      // ---- report ----
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/image_renderer.md
IMAGE_RENDERER -- requirements
Module: image_renderer

Interface
REQ-001 SHALL have parameters: IMG_W 175, source image width in pixels; IMG_H 480, source image height; SCR_W 640, screen width; SCR_H 480, screen height; IDX_BITS 4, palette index width; ADDR_BITS 17, ROM address width; FRAMES_PER_STEP 2, frames per fade level step.
REQ-002 SHALL have one clock and an asynchronous, active-high reset; the ports are vga_clk and reset.
REQ-003 SHALL have these ports, as name  direction  width  meaning:
- vga_clk  in  1  pixel clock.
- reset  in  1  async active-high reset.
- DrawX, DrawY  in  10 each  current pixel coordinate.
- blank  in  1  high = active video.
- fade_in_req, fade_out_req  in  1 each  single-cycle fade commands.
- rom_address  out  ADDR_BITS  image ROM address (registered).
- rom_q  in  IDX_BITS  ROM data, valid one cycle after rom_address.
- pal_index  out  IDX_BITS  registered rom_q, drives the external combinational palette.
- pal_red, pal_green, pal_blue  in  4 each  palette colour for pal_index.
- red, green, blue  out  4 each  final colour.
- fade_level  out  5  current level, 0..16.
- fade_busy  out  1  high while FADING_IN or FADING_OUT.

Function
REQ-004 SHALL form rom_address = floor(DrawX*IMG_W/SCR_W) + floor(DrawY*IMG_H/SCR_H)*IMG_W; this is exact whenever DrawX runs 0,1,2,… on consecutive cycles within a line.
REQ-005 SHALL generate the address with x/y accumulators (DDA); no runtime divide or multiply-by-DrawX operators are used.
- x accumulator: cleared when DrawX==0, then adds IMG_W per pixel, with wrap at SCR_W.
- y accumulator: steps once when DrawX==0 and DrawY differs from the previous line's DrawY; cleared when DrawY==0.
REQ-006 SHALL hold rom_address for DrawX>=SCR_W or DrawY>=SCR_H.
REQ-007 SHALL use a 3-stage pipeline: rom_address, pal_index and red/green/blue are each registered, so colour appears 3 vga_clk after its DrawX/DrawY.
REQ-008 SHALL delay blank by 3 stages; output 0 on all channels when the delayed blank is 0.
REQ-009 SHALL compute each channel as (pal_c * fade_level) >> 4, with a 9-bit intermediate; level 16 passes the palette value unchanged and level 0 gives black.
REQ-010 SHALL generate one frame_tick per frame, on the first cycle with DrawX==0 && DrawY==0; it does not repeat while the coordinate is held.
REQ-011 SHALL implement fade FSM states DARK, FADING_IN, SHOWN, FADING_OUT.
- fade_in_req: DARK or FADING_OUT -> FADING_IN.
- fade_out_req: SHOWN or FADING_IN -> FADING_OUT.
- Requests in any other state are ignored.
REQ-012 SHALL ignore both requests when both are asserted in the same cycle.
REQ-013 SHALL apply level steps as follows:
- In FADING_IN, increment fade_level by 1 every FRAMES_PER_STEP frame_ticks.
- At 16 -> SHOWN.
- FADING_OUT decrements the same way; at 0 -> DARK.
- The frame counter clears on every state transition.
REQ-014 SHALL apply a state change first when a request coincides with a frame_tick; that tick is not counted.
REQ-015 SHALL drive fade_busy combinationally from the state.

Reset
REQ-016 SHALL set, on reset: state DARK, fade_level 0, frame counter 0, accumulators 0, rom_address 0, pal_index 0, red/green/blue 0, and the blank pipeline 0.
REQ-017 SHALL produce black output for 3 cycles after reset release regardless of blank.

Structure
REQ-018 SHALL place the fade state enum and the level constants (LEVEL_MAX=16, LEVEL_BITS=5) in shared package render_pkg.
REQ-019 SHALL implement the FSM and frame counter as sub-module fade_ctrl, with inputs frame_tick and the two requests, and outputs fade_level and fade_busy; address generation and pipeline stay in image_renderer.

Verification
REQ-020 SHALL cover at least these bench scenarios:
- Default params, scan line DrawY=0 from DrawX 0..639: rom_address at DrawX=639 is 174, and at DrawX=320 is 87; DrawY=1 DrawX=0 gives 175.
- Full fade-in: fade_in_req, FRAMES_PER_STEP=2: fade_level reaches 16 after 32 frame_ticks, state SHOWN, fade_busy falls the same cycle; with pal_red=0xF at level 8, red=0x7.
- Reversal: fade_out_req at level 5 during FADING_IN: level decrements from 5 to 0 then DARK; simultaneous fade_in_req and fade_out_req leaves state unchanged.
- Blank alignment: blank low at cycle N gives red/green/blue=0 exactly at cycle N+3; rom_q=3 with palette 0xA,0x5,0x1 at level 16 gives 0xA,0x5,0x1 at the output.
- Reset mid-fade (level 9, FADING_IN): all outputs 0 immediately, state DARK; a new fade_in_req restarts from 0.
